// File: rtl/reg_mem_ctrl_pkg.sv
// Shared definitions for the reg_mem two-requester arbiter.
// FSM state encodings, requester count and the owner-to-one-hot helper.
package reg_mem_ctrl_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2,
        ST_INIT  = 2'd3
    } state_t;

    // Requester index (0/1) to one-hot pulse vector.
    function automatic logic [NUM_REQ-1:0] owner_onehot(input logic owner);
        return {owner, ~owner};
    endfunction

endpackage

// File: rtl/reg_mem_arbiter_rr_arb2.sv
// Combinational 2-way round-robin grant.
// With a single valid the grant goes to it; with both valid the grant goes
// to the requester that was not served last.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last,
    output logic [1:0] grant
);

    assign grant[0] = valid[0] & (~valid[1] | last);
    assign grant[1] = valid[1] & (~valid[0] | ~last);

endmodule

// File: rtl/reg_mem_arbiter.sv
// Shares one sync-read reg_mem port between two requesters.
// One transaction at a time, sequenced IDLE -> ISSUE -> RESP -> IDLE.
// Optional macro MEM_INIT_EN: after reset, sweep-clears the memory (INIT
// state, one address per cycle) before accepting any request.
module reg_mem_arbiter #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_BITS  = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              req_valid,
    input  logic [1:0]              req_wen,
    input  logic [2*ADDR_BITS-1:0]  req_addr,
    input  logic [2*DATA_WIDTH-1:0] req_wdata,
    output logic [1:0]              req_ready,
    output logic [1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    busy,
    output logic [ADDR_BITS-1:0]    mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_data_in,
    output logic                    mem_wen,
    input  logic [DATA_WIDTH-1:0]   mem_data_out
);
    import reg_mem_ctrl_pkg::*;

`ifdef MEM_INIT_EN
    localparam state_t RESET_STATE = ST_INIT;
`else
    localparam state_t RESET_STATE = ST_IDLE;
`endif

    state_t                  r_state;
    logic [ADDR_BITS-1:0]    r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic                    r_wen;
    logic                    r_owner;
    logic                    r_rr_last;
`ifdef MEM_INIT_EN
    logic [ADDR_BITS-1:0]    r_init_addr;
`endif

    logic [NUM_REQ-1:0]      w_grant;
    logic                    w_grant_idx;
    logic [ADDR_BITS-1:0]    w_req_addr  [NUM_REQ];
    logic [DATA_WIDTH-1:0]   w_req_wdata [NUM_REQ];

    // Split the packed request buses into per-requester fields.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_req_addr[gi]  = req_addr[gi*ADDR_BITS +: ADDR_BITS];
            assign w_req_wdata[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    rr_arb2 u_arb (
        .valid (req_valid),
        .last  (r_rr_last),
        .grant (w_grant)
    );

    // Grant is one-hot, so bit 1 alone identifies the winner.
    assign w_grant_idx = w_grant[1];

    // FSM: capture the granted request in IDLE, then issue and respond.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= RESET_STATE;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wen     <= 1'b0;
            r_owner   <= 1'b0;
            r_rr_last <= 1'b1;
`ifdef MEM_INIT_EN
            r_init_addr <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|req_valid) begin
                        r_addr    <= w_req_addr[w_grant_idx];
                        r_wdata   <= w_req_wdata[w_grant_idx];
                        r_wen     <= req_wen[w_grant_idx];
                        r_owner   <= w_grant_idx;
                        r_rr_last <= w_grant_idx;
                        r_state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: r_state <= ST_RESP;
                ST_RESP:  r_state <= ST_IDLE;
                ST_INIT: begin
`ifdef MEM_INIT_EN
                    r_init_addr <= r_init_addr + 1'b1;
                    if (r_init_addr == {ADDR_BITS{1'b1}}) begin
                        r_state <= ST_IDLE;
                    end
`else
                    r_state <= ST_IDLE;
`endif
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Memory port: captured request, write strobe only during ISSUE.
    always_comb begin
        mem_addr    = r_addr;
        mem_data_in = r_wdata;
        mem_wen     = (r_state == ST_ISSUE) && r_wen;
`ifdef MEM_INIT_EN
        if (r_state == ST_INIT) begin
            mem_addr    = r_init_addr;
            mem_data_in = '0;
            mem_wen     = 1'b1;
        end
`endif
    end

    // Handshake and response outputs decoded from the state register;
    // ready is the only path combinational in the request inputs.
    always_comb begin
        req_ready = (r_state == ST_IDLE) ? w_grant : '0;
        rsp_valid = (r_state == ST_RESP) ? owner_onehot(r_owner) : '0;
        rsp_rdata = (r_state == ST_RESP) ? mem_data_out : '0;
        busy      = (r_state != ST_IDLE);
    end

endmodule
